// File: rtl/mxv_pkg.sv
// -----------------------------------------------------------------------------
// mxv_pkg
// Shared constants and types for the matrix-vector result path.
//   DW_DBL      : width of one double-width accumulator result word
//   OUT_W       : width of one beat on the byte-oriented output path
//   SER_BEATS   : number of data beats needed to drain one word
//   ser_state_t : serializer state encoding (IDLE, SEND)
// -----------------------------------------------------------------------------
package mxv_pkg;

   localparam int unsigned DW_DBL    = 16;
   localparam int unsigned OUT_W     = 8;
   localparam int unsigned SER_BEATS = DW_DBL / OUT_W;

   typedef enum logic {
      IDLE,
      SEND
   } ser_state_t;

endpackage : mxv_pkg

// File: rtl/ser_beat_counter.sv
// -----------------------------------------------------------------------------
// ser_beat_counter
// Up-counter with synchronous clear, count enable and a terminal-count flag.
// Counts the beats of the word in flight inside dbl_word_serializer.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset (count -> 0)
//   clr_i    : synchronous clear, wins over en_i
//   en_i     : increment by one
//   count_o  : current count
//   tc_o     : count equals TERMINAL
// -----------------------------------------------------------------------------
module ser_beat_counter #(
   parameter int unsigned WIDTH    = 2,
   parameter int unsigned TERMINAL = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] count_o,
   output logic             tc_o
);

   logic [WIDTH-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else if (clr_i) begin
         count_q <= '0;
      end else if (en_i) begin
         count_q <= count_q + WIDTH'(1);
      end
   end

   assign count_o = count_q;
   assign tc_o    = (count_q == WIDTH'(TERMINAL));

endmodule : ser_beat_counter

// File: rtl/dbl_word_serializer.sv
// -----------------------------------------------------------------------------
// dbl_word_serializer
// Captures one DW_DBL-bit result word and emits it as DW_DBL/OUT_W beats of
// OUT_W bits over a valid/ready handshake, most-significant slice first.
// Optional feature macro: SER_CHKSUM_EN appends one beat carrying the XOR of
// all data slices; out_last then marks that checksum beat.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset, dominates flush
//   flush     : synchronous abort of the word in flight (also blocks capture)
//   in_valid  : in_data holds a word
//   in_ready  : word accepted this cycle if in_valid (registered, state only)
//   in_data   : word to serialize
//   out_valid : out_data holds a beat
//   out_ready : downstream accepts the beat
//   out_data  : current beat
//   out_last  : current beat is the final one of the word
//   busy      : a word is in flight
// -----------------------------------------------------------------------------
module dbl_word_serializer #(
   parameter int unsigned DW_DBL = mxv_pkg::DW_DBL,
   parameter int unsigned OUT_W  = mxv_pkg::OUT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DW_DBL-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_last,
   output logic              busy
);

   import mxv_pkg::*;

   localparam int unsigned BEATS = DW_DBL / OUT_W;
`ifdef SER_CHKSUM_EN
   localparam int unsigned TOTAL = BEATS + 1;
`else
   localparam int unsigned TOTAL = BEATS;
`endif
   localparam int unsigned CNT_W = $clog2(TOTAL + 1);

   ser_state_t        state_q;
   logic [DW_DBL-1:0] shift_q;
   logic [DW_DBL-1:0] shift_d;
   logic              in_ready_q;
   logic [CNT_W-1:0]  beat_cnt;
   logic              beat_tc;
   logic [OUT_W-1:0]  head_slice;
   logic              data_beat;
   logic              capture;
   logic              cnt_clr;
   logic              cnt_en;
`ifdef SER_CHKSUM_EN
   logic [OUT_W-1:0]  chk_q;
`endif

   assign head_slice = shift_q[DW_DBL-1 -: OUT_W];
   assign shift_d    = shift_q << OUT_W;
   // Beats below BEATS come from the shift register; the one after them (if
   // present) is the checksum beat.
   assign data_beat  = (beat_cnt < CNT_W'(BEATS));
   assign capture    = (state_q == IDLE) && in_ready_q && in_valid && !flush;
   assign cnt_clr    = flush || capture;
   assign cnt_en     = (state_q == SEND) && out_ready && data_beat && !flush;

   ser_beat_counter #(
      .WIDTH    (CNT_W),
      .TERMINAL (TOTAL - 1)
   ) u_beat_counter (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (cnt_clr),
      .en_i    (cnt_en),
      .count_o (beat_cnt),
      .tc_o    (beat_tc)
   );

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register here samples the same pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         in_ready_q <= 1'b0;
`ifdef SER_CHKSUM_EN
         chk_q      <= '0;
`endif
      end else if (flush) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         in_ready_q <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               in_ready_q <= 1'b1;
               if (capture) begin
                  shift_q    <= in_data;
                  state_q    <= SEND;
                  in_ready_q <= 1'b0;
`ifdef SER_CHKSUM_EN
                  chk_q      <= '0;
`endif
               end
            end
            SEND: begin
               if (out_ready) begin
                  if (data_beat) begin
                     shift_q <= shift_d;
`ifdef SER_CHKSUM_EN
                     chk_q   <= chk_q ^ head_slice;
`endif
                  end
                  // Word fully drained: in_ready rises the cycle after.
                  if (beat_tc) begin
                     state_q    <= IDLE;
                     in_ready_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q    <= IDLE;
               in_ready_q <= 1'b0;
            end
         endcase
      end
   end

   // NOTE: out_data gets its default first so this block can never infer a latch.
   always_comb begin
      out_data = head_slice;
`ifdef SER_CHKSUM_EN
      if (!data_beat) begin
         out_data = chk_q;
      end
`endif
   end

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q == SEND);
   assign busy      = (state_q == SEND);
   // Gated by state: after the checksum beat the counter rests on TOTAL-1.
   assign out_last  = (state_q == SEND) && beat_tc;

endmodule : dbl_word_serializer

// File: tb/tb_dbl_word_serializer.sv
// -----------------------------------------------------------------------------
// tb_dbl_word_serializer
// Self-checking bench for dbl_word_serializer (default 16-bit words, 8-bit
// beats). Honours SER_CHKSUM_EN for the expected beat sequence.
// -----------------------------------------------------------------------------
module tb_dbl_word_serializer;

   localparam int unsigned DW = mxv_pkg::DW_DBL;
   localparam int unsigned OW = mxv_pkg::OUT_W;
   localparam int unsigned NB = DW / OW;
`ifdef SER_CHKSUM_EN
   localparam bit          CHK = 1'b1;
   localparam int unsigned NT  = NB + 1;
`else
   localparam bit          CHK = 1'b0;
   localparam int unsigned NT  = NB;
`endif

   logic          clk;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [OW-1:0] out_data;
   logic          out_last;
   logic          busy;

   dbl_word_serializer dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_pass   = 0;

   logic [OW-1:0] exp_q[$];
   logic [OW-1:0] got_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: slice the word MSB-first with plain arithmetic, then the XOR.
   function automatic void build_exp(input logic [DW-1:0] w);
      logic [OW-1:0] x;
      logic [OW-1:0] s;
      exp_q.delete();
      x = '0;
      for (int i = 0; i < int'(NB); i++) begin
         s = OW'(w >> ((int'(NB) - 1 - i) * int'(OW)));
         exp_q.push_back(s);
         x = x ^ s;
      end
      if (CHK) exp_q.push_back(x);
   endfunction

   // Capture one word and drain it, checking every presented beat.
   task automatic send_word(input logic [DW-1:0] w, input int stall0, input bit rnd,
                            input string tag);
      int waited;
      int st;
      waited = 0;
      while (!in_ready && waited < 20) begin
         tick();
         waited++;
      end
      check({tag, "_in_ready_pre"}, in_ready, 1);
      in_valid  = 1'b1;
      in_data   = w;
      out_ready = 1'b1;
      tick();
      in_valid  = 1'b0;
      in_data   = DW'($urandom);
      for (int k = 0; k < exp_q.size(); k++) begin
         st = (k == 0) ? stall0 : 0;
         if (rnd) st = $urandom_range(0, 2);
         check({tag, "_valid"}, out_valid, 1);
         check({tag, "_data"}, out_data, exp_q[k]);
         check({tag, "_last"}, out_last, (k == exp_q.size() - 1));
         check({tag, "_in_ready_busy"}, in_ready, 0);
         if (st > 0) begin
            out_ready = 1'b0;
            repeat (st) begin
               tick();
               check({tag, "_stall_valid"}, out_valid, 1);
               check({tag, "_stall_data"}, out_data, exp_q[k]);
               check({tag, "_stall_last"}, out_last, (k == exp_q.size() - 1));
            end
            out_ready = 1'b1;
         end
         tick();
      end
      check({tag, "_done_valid"}, out_valid, 0);
      check({tag, "_done_in_ready"}, in_ready, 1);
      check({tag, "_done_busy"}, busy, 0);
   endtask

   typedef struct {
      logic [15:0] word;
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic [7:0]  ck;
      int          stall;
   } vec_t;

   vec_t vecs[6];
   int   acc_cyc[2];
   int   accepts;
   logic [DW-1:0] w;

   initial begin
      vecs[0] = '{word: 16'hA55A, b0: 8'hA5, b1: 8'h5A, ck: 8'hFF, stall: 0};
      vecs[1] = '{word: 16'h1234, b0: 8'h12, b1: 8'h34, ck: 8'h26, stall: 0};
      vecs[2] = '{word: 16'hBEEF, b0: 8'hBE, b1: 8'hEF, ck: 8'h51, stall: 5};
      vecs[3] = '{word: 16'h0000, b0: 8'h00, b1: 8'h00, ck: 8'h00, stall: 1};
      vecs[4] = '{word: 16'hFFFF, b0: 8'hFF, b1: 8'hFF, ck: 8'h00, stall: 0};
      vecs[5] = '{word: 16'h8001, b0: 8'h80, b1: 8'h01, ck: 8'h81, stall: 2};

      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;

      // Reset state
      tick();
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_data", out_data, 0);
      check("rst_busy", busy, 0);
      tick();
      rst = 1'b0;
      tick();
      check("post_rst_in_ready", in_ready, 1);

      // Table-driven words
      for (int i = 0; i < 6; i++) begin
         exp_q.delete();
         exp_q.push_back(vecs[i].b0);
         exp_q.push_back(vecs[i].b1);
         if (CHK) exp_q.push_back(vecs[i].ck);
         send_word(vecs[i].word, vecs[i].stall, 1'b0, $sformatf("vec%0d", i));
      end

      // Flush in IDLE blocks capture
      in_valid = 1'b1;
      in_data  = 16'h4242;
      flush    = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("idle_flush_valid", out_valid, 0);
      check("idle_flush_busy", busy, 0);
      check("idle_flush_in_ready", in_ready, 1);

      // Flush while the first beat of 16'hC0DE is stalled
      in_valid  = 1'b1;
      in_data   = 16'hC0DE;
      out_ready = 1'b0;
      tick();
      in_valid  = 1'b0;
      check("flush_first_beat", out_data, 8'hC0);
      tick();
      check("flush_held_valid", out_valid, 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_valid", out_valid, 0);
      check("flush_busy", busy, 0);
      check("flush_last", out_last, 0);
      check("flush_in_ready", in_ready, 1);
      out_ready = 1'b1;
      repeat (4) begin
         tick();
         check("flush_no_residual", out_valid, 0);
      end
      build_exp(16'h0102);
      send_word(16'h0102, 0, 1'b0, "after_flush");

      // Reset during the second beat
      in_valid  = 1'b1;
      in_data   = 16'h3C5A;
      out_ready = 1'b1;
      tick();
      in_valid  = 1'b0;
      check("rstmid_beat0", out_data, 8'h3C);
      tick();
      check("rstmid_beat1", out_data, 8'h5A);
      rst = 1'b1;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("rstmid_in_ready", in_ready, 0);
      check("rstmid_valid", out_valid, 0);
      check("rstmid_last", out_last, 0);
      check("rstmid_data", out_data, 0);
      check("rstmid_busy", busy, 0);
      rst = 1'b0;
      tick();
      check("rstmid_post_in_ready", in_ready, 1);
      check("rstmid_post_valid", out_valid, 0);
      repeat (3) begin
         tick();
         check("rstmid_no_residual", out_valid, 0);
      end

      // Input hold-off: two words offered back-to-back
      got_q.delete();
      accepts   = 0;
      in_valid  = 1'b1;
      in_data   = 16'h7777;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 40 && got_q.size() < 2 * NT; cyc++) begin
         if (in_valid && in_ready && accepts < 2) begin
            acc_cyc[accepts] = cyc;
            accepts++;
         end
         if (out_valid && out_ready) got_q.push_back(out_data);
         tick();
         if (accepts == 1) in_data = 16'h8888;
         if (accepts == 2) in_valid = 1'b0;
      end
      tick();
      check("holdoff_accepts", accepts, 2);
      if (accepts == 2) check("holdoff_gap", acc_cyc[1] - acc_cyc[0], NT + 1);
      build_exp(16'h7777);
      begin
         logic [OW-1:0] second[$];
         second = exp_q;
         build_exp(16'h8888);
         second = {second, exp_q};
         check("holdoff_count", got_q.size(), second.size());
         for (int i = 0; i < second.size() && i < got_q.size(); i++)
            check($sformatf("holdoff_beat%0d", i), got_q[i], second[i]);
      end
      check("holdoff_idle", out_valid, 0);

      // Randomized words with random backpressure
      for (int n = 0; n < 40; n++) begin
         repeat ($urandom_range(0, 2)) tick();
         w = DW'($urandom);
         build_exp(w);
         send_word(w, 0, 1'b1, $sformatf("rnd%0d", n));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_dbl_word_serializer
